// File: rtl/gf180mcu_osu_sc_seq_pkg.sv
// Shared types and defaults for the 12T buffer-bank enable sequencer.
package gf180mcu_osu_sc_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_ON   = 2'd2,
        S_DOWN = 2'd3
    } seq_state_e;

    localparam int DEF_NBANK = 4;
    localparam int DEF_CW    = 4;

endpackage

// File: rtl/gf180mcu_osu_sc_12T_seq_tmr.sv
// Step-interval counter: pulses step when the count reaches the latched gap,
// then restarts from zero on its own.
module gf180mcu_osu_sc_12T_seq_tmr
    import gf180mcu_osu_sc_seq_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [CW-1:0] dly,
    output logic          step
);

    logic [CW-1:0] cnt;

    assign step = (cnt == dly);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || step) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gf180mcu_osu_sc_12t_drv_seq.sv
// Staggered enable sequencer for high-drive buffer banks: ramps up lowest-first,
// down highest-first. Optional bank skip mask under DRV_SEQ_MASK_EN.
module gf180mcu_osu_sc_12t_drv_seq
    import gf180mcu_osu_sc_seq_pkg::*;
#(
    parameter int NBANK = DEF_NBANK,
    parameter int CW    = DEF_CW
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             REQ,
    input  logic [CW-1:0]    DLY,
`ifdef DRV_SEQ_MASK_EN
    input  logic [NBANK-1:0] MASK,
`endif
    output logic [NBANK-1:0] EN,
    output logic             ACK,
    output logic             BUSY
);

    seq_state_e       state, state_nxt;
    logic [NBANK-1:0] en_nxt;
    logic [NBANK-1:0] mask_in, mask_q;
    logic [CW-1:0]    dly_q;
    logic             latch, tmr_clr, step;

`ifdef DRV_SEQ_MASK_EN
    assign mask_in = MASK;
`else
    assign mask_in = '0;
`endif

    function automatic logic [NBANK-1:0] lowest(input logic [NBANK-1:0] v);
        return v & (~v + NBANK'(1));
    endfunction

    function automatic logic [NBANK-1:0] highest(input logic [NBANK-1:0] v);
        logic [NBANK-1:0] r;
        r = '0;
        for (int i = 0; i < NBANK; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Reversal into UP searches with the mask being latched on that same edge.
    logic [NBANK-1:0] lo_q, lo_in, hi_en;
    logic             all_on;

    assign lo_q   = lowest(~EN & ~mask_q);
    assign lo_in  = lowest(~EN & ~mask_in);
    assign hi_en  = highest(EN);
    assign all_on = ((~EN & ~mask_q) == '0);

    gf180mcu_osu_sc_12T_seq_tmr #(.CW(CW)) u_tmr (
        .clk   (CLK),
        .rst_n (RN),
        .clr   (tmr_clr),
        .dly   (dly_q),
        .step  (step)
    );

    always_comb begin
        state_nxt = state;
        en_nxt    = EN;
        latch     = 1'b0;
        tmr_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                tmr_clr = 1'b1;
                if (REQ) begin
                    state_nxt = S_UP;
                    en_nxt    = EN | lo_in;
                    latch     = 1'b1;
                end
            end
            S_UP: begin
                if (!REQ) begin
                    state_nxt = S_DOWN;
                    en_nxt    = EN & ~hi_en;
                    latch     = 1'b1;
                    tmr_clr   = 1'b1;
                end else if (all_on) begin
                    state_nxt = S_ON;
                    tmr_clr   = 1'b1;
                end else if (step) begin
                    en_nxt = EN | lo_q;
                end
            end
            S_ON: begin
                tmr_clr = 1'b1;
                if (!REQ) begin
                    state_nxt = S_DOWN;
                    en_nxt    = EN & ~hi_en;
                    latch     = 1'b1;
                end
            end
            S_DOWN: begin
                if (REQ) begin
                    state_nxt = S_UP;
                    en_nxt    = EN | lo_in;
                    latch     = 1'b1;
                    tmr_clr   = 1'b1;
                end else if (EN == '0) begin
                    state_nxt = S_IDLE;
                    tmr_clr   = 1'b1;
                end else if (step) begin
                    en_nxt = EN & ~hi_en;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state  <= S_IDLE;
            EN     <= '0;
            ACK    <= 1'b0;
            BUSY   <= 1'b0;
            dly_q  <= '0;
            mask_q <= '0;
        end else begin
            state <= state_nxt;
            EN    <= en_nxt;
            ACK   <= (state_nxt == S_ON);
            BUSY  <= (state_nxt == S_UP) || (state_nxt == S_DOWN);
            if (latch) begin
                dly_q  <= DLY;
                mask_q <= mask_in;
            end
        end
    end

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_drv_seq.sv
// Directed bench for the drive-bank sequencer; mask steps run only when
// DRV_SEQ_MASK_EN is defined.
module tb_gf180mcu_osu_sc_12t_drv_seq;

    logic       CLK = 1'b0;
    logic       RN  = 1'b0;
    logic       REQ = 1'b0;
    logic [3:0] DLY = '0;
    logic [3:0] MASK = '0;
    logic [3:0] EN;
    logic       ACK, BUSY;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    gf180mcu_osu_sc_12t_drv_seq #(.NBANK(4), .CW(4)) dut (
        .CLK  (CLK),
        .RN   (RN),
        .REQ  (REQ),
        .DLY  (DLY),
`ifdef DRV_SEQ_MASK_EN
        .MASK (MASK),
`endif
        .EN   (EN),
        .ACK  (ACK),
        .BUSY (BUSY)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [3:0] en_e, input logic ack_e, input logic busy_e);
        chk({tag, ".en"}, EN, en_e);
        chk({tag, ".ack"}, {3'b0, ACK}, {3'b0, ack_e});
        chk({tag, ".busy"}, {3'b0, BUSY}, {3'b0, busy_e});
    endtask

    logic [3:0] up_en [11];
    logic [3:0] dn_en [5];
    logic [3:0] rv_en [9];

    initial begin
        up_en = '{4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h3, 4'h7, 4'h7, 4'h7, 4'hF, 4'hF};
        dn_en = '{4'h7, 4'h3, 4'h1, 4'h0, 4'h0};
        rv_en = '{4'h1, 4'h1, 4'h1, 4'h3, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};

        // Reset state
        tick();
        tick();
        chk3("reset", 4'h0, 1'b0, 1'b0);
        RN = 1'b1;
        tick();
        chk3("idle", 4'h0, 1'b0, 1'b0);

        // Ramp up DLY=2; DLY dropped to 0 after latch must not change spacing
        REQ = 1'b1;
        DLY = 4'd2;
        for (int e = 0; e <= 10; e++) begin
            tick();
            if (e == 0) DLY = 4'd0;
            chk3($sformatf("up%0d", e), up_en[e], e >= 10, e <= 9);
        end

        // Ramp down DLY=0
        REQ = 1'b0;
        DLY = 4'd0;
        for (int e = 0; e <= 4; e++) begin
            tick();
            chk3($sformatf("dn%0d", e), dn_en[e], 1'b0, e <= 3);
        end

        // Reversal at edge 4 of an up-ramp, DLY=2
        REQ = 1'b1;
        DLY = 4'd2;
        for (int e = 0; e <= 8; e++) begin
            tick();
            if (e == 3) REQ = 1'b0;
            chk3($sformatf("rev%0d", e), rv_en[e], 1'b0, e <= 7);
        end

        // Reset mid-ramp, DLY=0
        REQ = 1'b1;
        DLY = 4'd0;
        tick();
        tick();
        tick();
        chk("pre_rst.en", EN, 4'h7);
        #2 RN = 1'b0;
        #1;
        chk3("rst_mid", 4'h0, 1'b0, 1'b0);
        #1 RN = 1'b1;
        tick();
        chk3("restart0", 4'h1, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        chk3("restart3", 4'hF, 1'b0, 1'b1);
        tick();
        chk3("restart_on", 4'hF, 1'b1, 1'b0);
        REQ = 1'b0;
        for (int e = 0; e <= 4; e++) tick();
        chk3("restart_idle", 4'h0, 1'b0, 1'b0);

`ifdef DRV_SEQ_MASK_EN
        MASK = 4'b0101;
        DLY  = 4'd1;
        REQ  = 1'b1;
        tick();
        MASK = 4'b0000;
        chk3("mask0", 4'b0010, 1'b0, 1'b1);
        tick();
        chk3("mask1", 4'b0010, 1'b0, 1'b1);
        tick();
        chk3("mask2", 4'b1010, 1'b0, 1'b1);
        tick();
        chk3("mask3", 4'b1010, 1'b1, 1'b0);
        REQ = 1'b0;
        for (int e = 0; e <= 5; e++) tick();
        chk3("mask_idle", 4'h0, 1'b0, 1'b0);

        MASK = 4'b1111;
        REQ  = 1'b1;
        tick();
        chk3("maskall0", 4'h0, 1'b0, 1'b1);
        tick();
        chk3("maskall1", 4'h0, 1'b1, 1'b0);
        REQ  = 1'b0;
        MASK = 4'b0000;
        tick();
        tick();
        chk3("maskall_idle", 4'h0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
